// File: rtl/uart_bridge_pkg.sv
// Shared constants for the host <-> PMOD UART byte bridge.
// Mode encodings and the FIFO level-width helper.
package uart_bridge_pkg;

    localparam logic [1:0] MODE_BRIDGE   = 2'b00;
    localparam logic [1:0] MODE_LOOPBACK = 2'b01;
    localparam logic [1:0] MODE_ISOLATE  = 2'b10;

    // Occupancy needs one bit more than the address so that "full" is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; head is shown combinationally.
// A push into a full FIFO is taken only when a pop frees the head slot in the same cycle.
module uart_byte_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic [DATA_W-1:0]       head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = (level == PW'(DEPTH));
    assign empty     = (level == '0);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_bridge_fifo.sv
// Buffered byte bridge between the host and PMOD UART cores.
// Mode-selected routing into two FIFOs, drop-on-full receivers and saturating statistics.
module uart_bridge_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         clr_stats,
    input  logic [DATA_W-1:0]            host_rx_data,
    input  logic                         host_rx_valid,
    output logic                         host_rx_ready,
    output logic [DATA_W-1:0]            host_tx_data,
    output logic                         host_tx_valid,
    input  logic                         host_tx_ready,
    input  logic [DATA_W-1:0]            pmod_rx_data,
    input  logic                         pmod_rx_valid,
    output logic                         pmod_rx_ready,
    output logic [DATA_W-1:0]            pmod_tx_data,
    output logic                         pmod_tx_valid,
    input  logic                         pmod_tx_ready,
    output logic [lvl_w(FIFO_DEPTH)-1:0] h2p_level,
    output logic [lvl_w(FIFO_DEPTH)-1:0] p2h_level,
    output logic [CNT_W-1:0]             h2p_count,
    output logic [CNT_W-1:0]             p2h_count,
    output logic [CNT_W-1:0]             h2p_drop,
    output logic [CNT_W-1:0]             p2h_drop
);

    logic [1:0]        r_mode_q;
    logic              r_rx_ready;
    logic [CNT_W-1:0]  r_h2p_count, r_p2h_count, r_h2p_drop, r_p2h_drop;

    logic              w_host_acc, w_pmod_acc;
    logic              w_h2p_push, w_p2h_push;
    logic [DATA_W-1:0] w_h2p_data, w_p2h_data;
    logic              w_h2p_pop, w_p2h_pop;
    logic              w_h2p_full, w_p2h_full;
    logic              w_h2p_empty, w_p2h_empty;
    logic              w_h2p_wr, w_p2h_wr;
    logic              w_h2p_lost, w_p2h_lost;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic clr);
        if (clr)                return '0;
        if (inc && (cnt != '1)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // Receivers cannot stall, so ready is simply "out of reset".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q   <= MODE_BRIDGE;
            r_rx_ready <= 1'b0;
        end else begin
            r_mode_q   <= mode;
            r_rx_ready <= 1'b1;
        end
    end

    assign host_rx_ready = r_rx_ready;
    assign pmod_rx_ready = r_rx_ready;
    assign w_host_acc    = host_rx_valid & r_rx_ready;
    assign w_pmod_acc    = pmod_rx_valid & r_rx_ready;

    // Each FIFO has a single writer per mode; the reserved encoding behaves as bridge.
    always_comb begin
        w_h2p_push = 1'b0;
        w_h2p_data = host_rx_data;
        w_p2h_push = 1'b0;
        w_p2h_data = pmod_rx_data;
        case (r_mode_q)
            MODE_LOOPBACK: begin
                w_h2p_push = w_pmod_acc;
                w_h2p_data = pmod_rx_data;
                w_p2h_push = w_host_acc;
                w_p2h_data = host_rx_data;
            end
            MODE_ISOLATE: begin
                w_h2p_push = 1'b0;
                w_p2h_push = 1'b0;
            end
            default: begin
                w_h2p_push = w_host_acc;
                w_p2h_push = w_pmod_acc;
            end
        endcase
    end

    assign pmod_tx_valid = ~w_h2p_empty;
    assign host_tx_valid = ~w_p2h_empty;
    assign w_h2p_pop     = pmod_tx_valid & pmod_tx_ready;
    assign w_p2h_pop     = host_tx_valid & host_tx_ready;

    uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_h2p (
        .clk       (clk),
        .rst       (rst),
        .push      (w_h2p_push),
        .push_data (w_h2p_data),
        .pop       (w_h2p_pop),
        .full      (w_h2p_full),
        .empty     (w_h2p_empty),
        .level     (h2p_level),
        .head      (pmod_tx_data)
    );

    uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_p2h (
        .clk       (clk),
        .rst       (rst),
        .push      (w_p2h_push),
        .push_data (w_p2h_data),
        .pop       (w_p2h_pop),
        .full      (w_p2h_full),
        .empty     (w_p2h_empty),
        .level     (p2h_level),
        .head      (host_tx_data)
    );

    assign w_h2p_wr   = w_h2p_push & (~w_h2p_full | w_h2p_pop);
    assign w_p2h_wr   = w_p2h_push & (~w_p2h_full | w_p2h_pop);
    assign w_h2p_lost = w_h2p_push & w_h2p_full & ~w_h2p_pop;
    assign w_p2h_lost = w_p2h_push & w_p2h_full & ~w_p2h_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h2p_count <= '0;
            r_p2h_count <= '0;
            r_h2p_drop  <= '0;
            r_p2h_drop  <= '0;
        end else begin
            r_h2p_count <= sat_next(r_h2p_count, w_h2p_wr,   clr_stats);
            r_p2h_count <= sat_next(r_p2h_count, w_p2h_wr,   clr_stats);
            r_h2p_drop  <= sat_next(r_h2p_drop,  w_h2p_lost, clr_stats);
            r_p2h_drop  <= sat_next(r_p2h_drop,  w_p2h_lost, clr_stats);
        end
    end

    assign h2p_count = r_h2p_count;
    assign p2h_count = r_p2h_count;
    assign h2p_drop  = r_h2p_drop;
    assign p2h_drop  = r_p2h_drop;

endmodule
